// File: rtl/led_capture_pkg.sv
// led_capture_pkg: shared LED-monitor constants and types.
package led_capture_pkg;
    localparam int LED_COUNT = 64;
    localparam int CNT_W     = 4;
    localparam int ADDR_W    = $clog2(LED_COUNT);
    typedef logic [LED_COUNT-1:0] led_vec_t;
    typedef logic [ADDR_W-1:0]    led_addr_t;
    typedef logic [CNT_W-1:0]     hold_cnt_t;
endpackage

// File: rtl/led_capture_if.sv
// led_capture_if: static-bit write port with one-cycle acknowledge.
interface led_capture_if;
    import led_capture_pkg::*;
    logic      i_wr;
    logic      i_cs;
    led_addr_t i_addr;
    logic      i_val;
    logic      o_ack;
    modport master (output i_wr, i_cs, i_addr, i_val, input o_ack);
    modport slave  (input i_wr, i_cs, i_addr, i_val, output o_ack);
endinterface

// File: rtl/led_capture_stretch_cell.sv
// led_stretch_cell: one LED's static bit plus a frame-counted pulse stretcher.
module led_stretch_cell
    import led_capture_pkg::*;
#(
    parameter int HOLD_FRAMES = 3
) (
    input  logic i_clk25Mhz,
    input  logic i_reset,
    input  logic wr_en_i,
    input  logic val_i,
    input  logic pulse_i,
    input  logic tick_i,
    input  logic clr_i,
    input  logic arm_i,
    output logic lit_o
);
    logic      s_q, s_d, p_q, p_d;
    hold_cnt_t a_q, a_d;
    logic      rise;
    assign rise  = arm_i & pulse_i & ~p_q;
    assign lit_o = s_q | (a_q != '0);
    // clear beats reload, reload beats the frame decrement
    always_comb begin
        p_d = pulse_i;
        s_d = clr_i ? 1'b0 : wr_en_i ? val_i : s_q;
        a_d = clr_i ? '0
            : rise ? CNT_W'(HOLD_FRAMES)
            : (tick_i && a_q != '0) ? a_q - CNT_W'(1)
            : a_q;
    end
    always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
        if (!i_reset) begin
            s_q <= 1'b0;
            p_q <= 1'b0;
            a_q <= '0;
        end else begin
            s_q <= s_d;
            p_q <= p_d;
            a_q <= a_d;
        end
    end
endmodule

// File: rtl/led_capture.sv
// led_capture: merges static bits and stretched pulses into a frame-stable LED vector.
module led_capture
    import led_capture_pkg::*;
#(
    parameter int NUM_LEDS    = LED_COUNT,
    parameter int HOLD_FRAMES = 3
) (
    input  logic                i_clk25Mhz,
    input  logic                i_reset,
    input  logic                i_frameStart,
    input  logic                i_clrAll,
    input  logic [NUM_LEDS-1:0] i_pulse,
    led_capture_if.slave        bus,
    output logic [NUM_LEDS-1:0] o_leds
);
    logic                ack_q, ack_d, run_q, accept;
    logic [NUM_LEDS-1:0] leds_q, leds_d, lit;
    assign accept    = bus.i_cs & bus.i_wr & ~i_clrAll;
    assign bus.o_ack = ack_q;
    assign o_leds    = leds_q;
    always_comb begin
        ack_d  = accept;
        leds_d = i_frameStart ? lit : leds_q;
    end
    // run_q masks edge detection on the first cycle after reset so a level
    // already high during reset is not mistaken for a new event
    always_ff @(posedge i_clk25Mhz or negedge i_reset) begin
        if (!i_reset) begin
            ack_q  <= 1'b0;
            run_q  <= 1'b0;
            leds_q <= '0;
        end else begin
            ack_q  <= ack_d;
            run_q  <= 1'b1;
            leds_q <= leds_d;
        end
    end
    for (genvar i = 0; i < NUM_LEDS; i++) begin : g_cell
        led_stretch_cell #(.HOLD_FRAMES(HOLD_FRAMES)) u_cell (
            .i_clk25Mhz(i_clk25Mhz),
            .i_reset   (i_reset),
            .wr_en_i   (accept && bus.i_addr == ADDR_W'(i)),
            .val_i     (bus.i_val),
            .pulse_i   (i_pulse[i]),
            .tick_i    (i_frameStart),
            .clr_i     (i_clrAll),
            .arm_i     (run_q),
            .lit_o     (lit[i])
        );
    end
endmodule
